// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared FSM states, vector count and golden response for the half-adder BIST
package half_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    localparam int NUM_VECTORS = 4;

    // Returns {sum, carry} for the vector {a, b}.
    function automatic logic [1:0] ha_golden(input logic [1:0] vec);
        return {vec[1] ^ vec[0], vec[1] & vec[0]};
    endfunction

endpackage

// File: rtl/half_adder_ref.sv
// rtl/half_adder_ref.sv - combinational golden half adder used as the expected response
module half_adder_ref
    import half_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign {sum_o, carry_o} = ha_golden({a_i, b_i});

endmodule

// File: rtl/half_adder_bist.sv
// rtl/half_adder_bist.sv - vector sequencer and response checker for an external half adder
module half_adder_bist
    import half_adder_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int PASSES = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_sum,
    input  logic             dut_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);
    localparam logic [1:0]      VEC_LAST    = 2'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [SC_W-1:0]  settle_q, settle_d;
    logic [1:0]       vec_q, vec_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;

    logic ref_sum, ref_carry;
    logic compare, mismatch, last_cmp;

    half_adder_ref u_ref (
        .a_i     (vec_q[1]),
        .b_i     (vec_q[0]),
        .sum_o   (ref_sum),
        .carry_o (ref_carry)
    );

    assign compare  = (state_q == ST_RUN) && (settle_q == SETTLE_LAST);
    assign mismatch = compare && ((dut_sum != ref_sum) || (dut_carry != ref_carry));
    assign last_cmp = compare && (vec_q == VEC_LAST) && (pcnt_q == PASS_LAST);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        vec_d     = vec_q;
        pcnt_d    = pcnt_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    settle_d  = '0;
                    vec_d     = '0;
                    pcnt_d    = '0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (compare) begin
                    settle_d = '0;
                    vec_d    = vec_q + 2'd1;
                    if (vec_q == VEC_LAST) begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                // The final compare's own result must count toward the verdict.
                if (last_cmp) begin
                    state_d = ST_FINISH;
                    pass_d  = !(ffvalid_q || mismatch);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            vec_q     <= '0;
            pcnt_q    <= '0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            vec_q     <= vec_d;
            pcnt_q    <= pcnt_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_FINISH);
    assign {dut_a, dut_b}   = busy ? vec_q : 2'b00;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule
